// File: rtl/jk_edge_mon.sv
// jk_edge_mon: tracks the level of an upstream JK trigger (q/nq pair),
// counts rising/falling edges and publishes finished run lengths through
// a valid/ready record. A q==nq sample is flagged as an error.
// Build option: define EDGE_MON_SAT_EN to make rise_cnt/fall_cnt saturate
// instead of wrapping.
module jk_edge_mon #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q,
  input  logic             nq,
  input  logic             clr,
  input  logic             run_ready,
  output logic             level,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             run_valid,
  output logic             run_level,
  output logic [RUN_W-1:0] run_len,
  output logic             ovf,
  output logic             err
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {INIT, LOW, HIGH, ERR} state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;

  logic             sample_ok_c;
  logic             edge_c;
  logic             xfer_c;
  logic [RUN_W-1:0] run_inc_c;
  logic [CNT_W-1:0] rise_inc_c;
  logic [CNT_W-1:0] fall_inc_c;

  // A clean sample has complementary outputs; an edge is a clean sample
  // that disagrees with the tracked level.
  assign sample_ok_c = (q != nq);
  assign edge_c      = sample_ok_c && (((state == LOW) && q) || ((state == HIGH) && !q));
  assign xfer_c      = run_valid && run_ready;
  assign run_inc_c   = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_ONE;

`ifdef EDGE_MON_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Edge counters stick at all-ones.
  assign rise_inc_c = (rise_cnt == CNT_MAX) ? rise_cnt : rise_cnt + CNT_ONE;
  assign fall_inc_c = (fall_cnt == CNT_MAX) ? fall_cnt : fall_cnt + CNT_ONE;
`else
  // Edge counters wrap modulo 2^CNT_W.
  assign rise_inc_c = rise_cnt + CNT_ONE;
  assign fall_inc_c = fall_cnt + CNT_ONE;
`endif

  // Level-tracking FSM, run counter, edge counters and record handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      run_cnt   <= '0;
      level     <= 1'b0;
      rise_cnt  <= '0;
      fall_cnt  <= '0;
      run_valid <= 1'b0;
      run_level <= 1'b0;
      run_len   <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      state     <= INIT;
      run_cnt   <= '0;
      level     <= 1'b0;
      rise_cnt  <= '0;
      fall_cnt  <= '0;
      run_valid <= 1'b0;
      run_level <= 1'b0;
      run_len   <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (!sample_ok_c) begin
        // Interrupted run is discarded; level keeps its last value.
        state <= ERR;
        err   <= 1'b1;
      end else begin
        case (state)
          INIT, ERR: begin
            state   <= q ? HIGH : LOW;
            level   <= q;
            run_cnt <= RUN_ONE;
          end
          LOW: begin
            if (q) begin
              state    <= HIGH;
              level    <= 1'b1;
              rise_cnt <= rise_inc_c;
              run_cnt  <= RUN_ONE;
            end else begin
              run_cnt  <= run_inc_c;
            end
          end
          HIGH: begin
            if (!q) begin
              state    <= LOW;
              level    <= 1'b0;
              fall_cnt <= fall_inc_c;
              run_cnt  <= RUN_ONE;
            end else begin
              run_cnt  <= run_inc_c;
            end
          end
          default: begin
            state   <= INIT;
            run_cnt <= '0;
          end
        endcase
      end

      // New record loads if the slot is empty or being drained this cycle.
      if (edge_c) begin
        if (!run_valid || run_ready) begin
          run_valid <= 1'b1;
          run_level <= level;
          run_len   <= run_cnt;
        end else begin
          ovf <= 1'b1;
        end
      end else if (xfer_c) begin
        run_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jk_edge_mon.sv
// Self-checking bench for jk_edge_mon: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_jk_edge_mon;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RUN_W = 3;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int RMAX = (1 << RUN_W) - 1;
`ifdef EDGE_MON_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             q = 1'b0;
  logic             nq = 1'b1;
  logic             clr = 1'b0;
  logic             run_ready = 1'b0;
  logic             level;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;
  logic             run_valid;
  logic             run_level;
  logic [RUN_W-1:0] run_len;
  logic             ovf;
  logic             err;

  int checks = 0;
  int failures = 0;

  jk_edge_mon #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst(rst), .q(q), .nq(nq), .clr(clr), .run_ready(run_ready),
    .level(level), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
    .run_valid(run_valid), .run_level(run_level), .run_len(run_len),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "tracking" means a known level exists (not INIT/ERR).
  typedef struct {
    int track;
    int lvl;
    int run;
    int rise;
    int fall;
    int valid;
    int rlev;
    int rlen;
    int ovf;
    int err;
  } mstate_t;

  mstate_t m = '{default: 0};

  function automatic int bump(input int c);
    if (SAT) return (c >= CMAX) ? CMAX : c + 1;
    return (c + 1) % (CMAX + 1);
  endfunction

  function automatic mstate_t next_model(input mstate_t s, input logic qi,
                                         input logic nqi, input logic rdy);
    mstate_t n = s;
    int newrec = 0;
    int nlev = 0;
    int nlen = 0;
    if (qi == nqi) begin
      n.track = 0;
      n.err = 1;
    end else if (n.track == 0) begin
      n.track = 1;
      n.lvl = int'(qi);
      n.run = 1;
    end else if (int'(qi) != n.lvl) begin
      newrec = 1;
      nlev = n.lvl;
      nlen = n.run;
      if (qi) n.rise = bump(n.rise);
      else n.fall = bump(n.fall);
      n.lvl = int'(qi);
      n.run = 1;
    end else begin
      n.run = (n.run < RMAX) ? n.run + 1 : RMAX;
    end
    if (newrec != 0) begin
      if (s.valid == 0 || rdy) begin
        n.valid = 1;
        n.rlev = nlev;
        n.rlen = nlen;
      end else begin
        n.ovf = 1;
      end
    end else if (s.valid != 0 && rdy) begin
      n.valid = 0;
    end
    return n;
  endfunction

  // Model advances on the same edges as the design.
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{default: 0};
    else if (clr) m <= '{default: 0};
    else m <= next_model(m, q, nq, run_ready);
  end

  // Compare process: outputs against model, away from the active edge.
  always @(negedge clk) begin
    chk("level", int'(level), m.lvl);
    chk("rise_cnt", int'(rise_cnt), m.rise);
    chk("fall_cnt", int'(fall_cnt), m.fall);
    chk("run_valid", int'(run_valid), m.valid);
    chk("run_level", int'(run_level), m.rlev);
    chk("run_len", int'(run_len), m.rlen);
    chk("ovf", int'(ovf), m.ovf);
    chk("err", int'(err), m.err);
  end

  task automatic step(input logic qi, input logic nqi, input logic ci, input logic ri);
    q = qi;
    nq = nqi;
    clr = ci;
    run_ready = ri;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset pulse landing between clock edges; outputs must clear at once.
  task automatic rst_pulse(input bit check_now);
    #2 rst = 1'b0;
    #1;
    if (check_now) begin
      chk("async_rst_valid", int'(run_valid), 0);
      chk("async_rst_rise", int'(rise_cnt), 0);
      chk("async_rst_level", int'(level), 0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int nrec;
    logic qv;
    logic nqv;
    logic q_last;

    @(negedge clk);
    @(negedge clk);
    chk("reset_level", int'(level), 0);
    chk("reset_rise", int'(rise_cnt), 0);
    chk("reset_valid", int'(run_valid), 0);
    chk("reset_len", int'(run_len), 0);
    rst = 1'b1;

    // Three low samples then a rise: record {0,3}.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("first_rec_valid", int'(run_valid), 1);
    chk("first_rec_level", int'(run_level), 0);
    chk("first_rec_len", int'(run_len), 3);
    chk("first_rise", int'(rise_cnt), 1);
    chk("first_fall", int'(fall_cnt), 0);
    chk("first_level", int'(level), 1);

    // Clear, then toggle every cycle for 10 samples: 9 one-cycle records.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    nrec = 0;
    for (int k = 0; k < 10; k++) begin
      step(logic'(k % 2), logic'(1 - (k % 2)), 1'b0, 1'b1);
      if (run_valid && run_len == RUN_W'(1)) nrec++;
    end
    chk("toggle_records", nrec, 9);
    chk("toggle_edges", int'(rise_cnt) + int'(fall_cnt), 9);
    chk("toggle_rise", int'(rise_cnt), 5);

    // Backpressure: first record held, second dropped with ovf.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("drain_valid", int'(run_valid), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("held_valid", int'(run_valid), 1);
    chk("held_level", int'(run_level), 1);
    chk("held_len", int'(run_len), 2);
    chk("ovf_set", int'(ovf), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("xfer_done", int'(run_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);

    // q==nq glitch inside a HIGH run: error, no record, run restarts.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("err_set", int'(err), 1);
    chk("err_level_hold", int'(level), 1);
    chk("err_no_rec", int'(run_valid), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("err_no_edge", int'(rise_cnt), 6);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("post_err_len", int'(run_len), 2);
    chk("post_err_rlev", int'(run_level), 1);
    chk("post_err_fall", int'(fall_cnt), 6);
    chk("err_sticky", int'(err), 1);

    // clr coinciding with an edge wins; next sample is INIT.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_rise", int'(rise_cnt), 0);
    chk("clr_fall", int'(fall_cnt), 0);
    chk("clr_valid", int'(run_valid), 0);
    chk("clr_flags", int'(ovf) + int'(err), 0);
    chk("clr_level", int'(level), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("after_clr_rise", int'(rise_cnt), 0);
    chk("after_clr_valid", int'(run_valid), 0);
    chk("after_clr_level", int'(level), 1);

    // 20 rising edges on a 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    chk("rise_20", int'(rise_cnt), SAT ? 15 : 4);
    chk("fall_20", int'(fall_cnt), SAT ? 15 : 4);

    // Reset mid-handshake discards the pending record.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pend_valid", int'(run_valid), 1);
    rst_pulse(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_rst_rise", int'(rise_cnt), 0);
    chk("post_rst_valid", int'(run_valid), 0);
    chk("post_rst_level", int'(level), 1);

    // Random traffic with sticky levels, glitches, clears and resets.
    q_last = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      qv = ($urandom_range(99) < 25) ? ~q_last : q_last;
      q_last = qv;
      nqv = ($urandom_range(99) < 4) ? qv : ~qv;
      if (i % 700 == 350) rst_pulse(1'b0);
      step(qv, nqv, logic'($urandom_range(99) < 2), logic'($urandom_range(99) < 50));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_edge_mon.md
JK_EDGE_MON -- requirements
Module: jk_edge_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the rise/fall edge counters.
REQ-002 SHALL have parameter RUN_W, default 8, width of the run-length counter and record.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port q  input  1  true output of the upstream JK trigger.
REQ-006 SHALL have port nq  input  1  complement output of the upstream JK trigger.
REQ-007 SHALL have port clr  input  1  synchronous clear of counters, flags and record.
REQ-008 SHALL have port run_ready  input  1  consumer accepts the record.
REQ-009 SHALL have port level  output  1  current tracked level of q.
REQ-010 SHALL have port rise_cnt  output  CNT_W  number of 0->1 transitions.
REQ-011 SHALL have port fall_cnt  output  CNT_W  number of 1->0 transitions.
REQ-012 SHALL have port run_valid  output  1  record holds a finished run.
REQ-013 SHALL have port run_level  output  1  level of the finished run.
REQ-014 SHALL have port run_len  output  RUN_W  cycle count of the finished run.
REQ-015 SHALL have port ovf  output  1  sticky flag: a record was dropped.
REQ-016 SHALL have port err  output  1  sticky flag: q==nq was sampled.

Function
REQ-017 SHALL sample q/nq on every posedge clk; all outputs SHALL be registered.
REQ-018 SHALL implement FSM states INIT, LOW, HIGH, ERR.
REQ-019 INIT: first sample with q!=nq moves to LOW (q=0) or HIGH (q=1); run counter=1; no edge counted; no record.
REQ-020 LOW with sampled q=1 (nq=0) SHALL go HIGH, increment rise_cnt, emit record {level 0, run count}, restart run counter at 1.
REQ-021 HIGH with sampled q=0 (nq=1) SHALL go LOW, increment fall_cnt, emit record {level 1, run count}, restart run counter at 1.
REQ-022 Same level sampled again SHALL increment the run counter, saturating at 2^RUN_W-1.
REQ-023 Any state sampling q==nq SHALL enter ERR and set err; the interrupted run SHALL be discarded without a record.
REQ-024 ERR sampling q!=nq SHALL go to LOW/HIGH per q with run=1, no edge counted, no record.
REQ-025 level SHALL equal the current LOW/HIGH state; it holds the last value in ERR and is 0 in INIT.
REQ-026 Latency: the level change is sampled at edge N; counters, level and record SHALL be visible after edge N.
REQ-027 Record handshake: the record is transferred on a posedge with run_valid=1 and run_ready=1; the record SHALL be held stable while run_valid=1 and run_ready=0.
REQ-028 A new record arriving when run_valid=1 and run_ready=0 SHALL be dropped, the old record kept, and ovf set.
REQ-029 A new record arriving on a transfer cycle (run_valid=1, run_ready=1) SHALL load with run_valid staying 1 and no ovf.
REQ-030 clr=1 SHALL zero rise_cnt, fall_cnt, ovf, err, run_valid and level, and SHALL force INIT; clr has priority over all events that cycle.
REQ-031 ovf and err SHALL clear only on clr or reset.

Reset
REQ-032 rst=0 SHALL immediately force INIT and set level=0, rise_cnt=0, fall_cnt=0, run_valid=0, run_level=0, run_len=0, ovf=0, err=0.
REQ-033 Reset asserted mid-run or mid-handshake SHALL discard the pending record; the first posedge after release SHALL behave as INIT.

Configuration
REQ-034 With macro EDGE_MON_SAT_EN defined, rise_cnt and fall_cnt SHALL saturate at 2^CNT_W-1; without it, they SHALL wrap to 0.

Verification
REQ-035 Reset release; q=0 for 3 samples, then q=1; run_ready=1 -> record {0,3}, rise_cnt=1, level=1, fall_cnt=0.
REQ-036 Toggle q every cycle for 10 cycles with run_ready=1 -> 9 records, each with run_len=1; rise_cnt+fall_cnt=9.
REQ-037 run_ready=0; two edges 2 cycles apart -> first record held unchanged; ovf=1 after the second edge; raising run_ready transfers the first record.
REQ-038 q=nq=1 for 1 cycle inside a HIGH run, then q=1 -> err=1, no record, no edge counted, run_len restarts at 1.
REQ-039 CNT_W=4; 20 rising edges -> rise_cnt=15 with EDGE_MON_SAT_EN defined, 4 without it.
REQ-040 clr pulsed in the same cycle as an edge -> all counters/flags 0, run_valid=0, FSM in INIT; the next sample counts no edge.
